// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Fetch stage. Owns the fetch PC and runs a single-outstanding
//               request/acknowledge transaction against instruction memory.
//               It presents one instruction per cycle, with its PC and PC+4,
//               to the fetch/decode register. It honours stalls and redirects
//               and drops responses that were already in flight when a
//               redirect arrived.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int unsigned                ADDRESS_WIDTH = 32,
    parameter int unsigned                DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_VECTOR  = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         stallF_i,
    input  logic                         pc_srcE_i,
    input  logic [ADDRESS_WIDTH-1:0]     pc_targetE_i,
    output logic                         imem_req_o,
    output logic [ADDRESS_WIDTH-1:0]     imem_addr_o,
    input  logic                         imem_ack_i,
    input  logic [DATA_WIDTH-1:0]        imem_rdata_i,
    output logic [DATA_WIDTH-1:0]        rd_o,
    output logic [ADDRESS_WIDTH-1:0]     pcF_o,
    output logic [ADDRESS_WIDTH-1:0]     pc_plus4F_o,
    output logic                         validF_o,
    output logic                         busyF_o
);

    // IDLE: no transaction held; WAIT: live transaction; DROP: transaction
    // whose response must be thrown away because a redirect overtook it.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] c_PC_STEP = ADDRESS_WIDTH'(4);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [ADDRESS_WIDTH-1:0]   r_pc;
    logic [ADDRESS_WIDTH-1:0]   w_pc_nxt;
    logic [ADDRESS_WIDTH-1:0]   r_addr;
    logic [ADDRESS_WIDTH-1:0]   w_addr_nxt;
    logic                       w_req;
    logic [ADDRESS_WIDTH-1:0]   w_req_addr;
    logic                       w_capture;
    logic                       w_space;

    logic [DATA_WIDTH-1:0]      r_rd;
    logic [ADDRESS_WIDTH-1:0]   r_pcF;
    logic [ADDRESS_WIDTH-1:0]   r_pc_plus4;
    logic                       r_valid;

    // Buffer can take a new instruction: empty, or being consumed this cycle.
    assign w_space = !r_valid || !stallF_i;

    // Next-state, next-PC and memory request decode.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_addr_nxt  = r_addr;
        w_req       = 1'b0;
        w_req_addr  = r_pc;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A redirect cycle never starts a transaction.
                w_req = w_space && !pc_srcE_i;
                if (pc_srcE_i) begin
                    w_pc_nxt = pc_targetE_i;
                end else if (w_req && imem_ack_i) begin
                    w_capture = 1'b1;
                    w_pc_nxt  = r_pc + c_PC_STEP;
                end else if (w_req) begin
                    w_addr_nxt  = r_pc;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_req      = 1'b1;
                w_req_addr = r_addr;
                if (pc_srcE_i) begin
                    w_pc_nxt    = pc_targetE_i;
                    w_state_nxt = imem_ack_i ? S_IDLE : S_DROP;
                end else if (imem_ack_i) begin
                    w_capture   = 1'b1;
                    w_pc_nxt    = r_addr + c_PC_STEP;
                    w_state_nxt = S_IDLE;
                end
            end
            S_DROP: begin
                w_req      = 1'b1;
                w_req_addr = r_addr;
                if (pc_srcE_i) begin
                    w_pc_nxt = pc_targetE_i;
                end
                if (imem_ack_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, fetch PC and held transaction address.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_VECTOR;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    // Output buffer: redirect flushes, capture loads, consumption empties.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd       <= '0;
            r_pcF      <= '0;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (pc_srcE_i) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_rd       <= imem_rdata_i;
            r_pcF      <= w_req_addr;
            r_pc_plus4 <= w_req_addr + c_PC_STEP;
            r_valid    <= 1'b1;
        end else if (!stallF_i) begin
            r_valid <= 1'b0;
        end
    end

    assign imem_req_o  = w_req && !rst_i;
    assign imem_addr_o = w_req_addr;
    assign rd_o        = r_rd;
    assign pcF_o       = r_pcF;
    assign pc_plus4F_o = r_pc_plus4;
    assign validF_o    = r_valid;
    assign busyF_o     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit with a transaction-level
//               reference model and a variable-latency memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] c_RV = 32'hFFFF_FFFC;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        stallF_i = 1'b0;
    logic        pc_srcE_i = 1'b0;
    logic [31:0] pc_targetE_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic [31:0] rd_o;
    logic [31:0] pcF_o;
    logic [31:0] pc_plus4F_o;
    logic        validF_o;
    logic        busyF_o;

    fetch_unit #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .RESET_VECTOR  (c_RV)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .stallF_i     (stallF_i),
        .pc_srcE_i    (pc_srcE_i),
        .pc_targetE_i (pc_targetE_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .rd_o         (rd_o),
        .pcF_o        (pcF_o),
        .pc_plus4F_o  (pc_plus4F_o),
        .validF_o     (validF_o),
        .busyF_o      (busyF_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: fetch PC, one outstanding transaction, output buffer.
    logic [31:0] m_pc = c_RV;
    logic        m_pending = 1'b0;
    logic        m_killed = 1'b0;
    logic [31:0] m_paddr = 32'h0;
    logic        m_valid = 1'b0;
    logic [31:0] m_rd = 32'h0;
    logic [31:0] m_pcF = 32'h0;
    logic [31:0] m_pc4 = 32'h0;

    // Memory model: ack after mem_lat wait cycles of continuous request.
    int mem_cnt = 0;
    int mem_lat = 0;
    int lat_lo  = 0;
    int lat_hi  = 0;

    logic [32:0] obs_req, exp_req;
    logic [97:0] obs_out, exp_out;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[31:16]};
    endfunction

    // One clock: drive inputs at negedge, respond as memory, advance model.
    task automatic step(input logic rst_v, input logic stall_v,
                        input logic src_v, input logic [31:0] tgt_v);
        logic        space, e_req, fire, deliver, req_now, ack_now;
        logic [31:0] e_addr;
        rst_i = rst_v; stallF_i = stall_v; pc_srcE_i = src_v; pc_targetE_i = tgt_v;
        imem_ack_i = 1'b0; imem_rdata_i = $urandom;
        #1;
        obs_req = {imem_req_o, imem_req_o ? imem_addr_o : 32'h0};
        space   = !m_valid || !stall_v;
        e_req   = rst_v ? 1'b0 : (m_pending ? 1'b1 : (space && !src_v));
        e_addr  = m_pending ? m_paddr : m_pc;
        exp_req = {e_req, e_req ? e_addr : 32'h0};
        if (imem_req_o === 1'b1 && mem_cnt >= mem_lat) begin
            imem_ack_i   = 1'b1;
            imem_rdata_i = mem_f(imem_addr_o);
        end
        req_now = (imem_req_o === 1'b1);
        ack_now = imem_ack_i;
        #1;
        if (rst_v) begin
            m_pc = c_RV; m_pending = 1'b0; m_killed = 1'b0; m_paddr = 32'h0;
            m_valid = 1'b0; m_rd = 32'h0; m_pcF = 32'h0; m_pc4 = 32'h0;
        end else begin
            fire    = e_req && imem_ack_i;
            deliver = fire && !m_killed && !src_v;
            if (src_v) m_valid = 1'b0;
            else if (deliver) begin
                m_rd = mem_f(e_addr); m_pcF = e_addr; m_pc4 = e_addr + 32'd4; m_valid = 1'b1;
            end else if (!stall_v) m_valid = 1'b0;
            if (src_v) m_pc = tgt_v;
            else if (deliver) m_pc = e_addr + 32'd4;
            if (fire) begin
                m_pending = 1'b0; m_killed = 1'b0;
            end else if (m_pending) begin
                if (src_v) m_killed = 1'b1;
            end else if (e_req) begin
                m_pending = 1'b1; m_paddr = e_addr; m_killed = 1'b0;
            end
        end
        @(posedge clk_i); #1;
        if (rst_v || !req_now) mem_cnt = 0;
        else if (ack_now) begin
            mem_cnt = 0; mem_lat = $urandom_range(lat_hi, lat_lo);
        end else mem_cnt++;
        obs_out = {rd_o, pcF_o, pc_plus4F_o, validF_o, busyF_o};
        exp_out = {m_rd, m_pcF, m_pc4, m_valid, m_pending};
        cyc++;
        @(negedge clk_i);
    endtask

    // Let any outstanding transaction finish (bounded).
    task automatic drain();
        for (int i = 0; i < 20 && m_pending; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (m_pending) begin
            n_fail++;
            $display("FAIL drain_timeout cyc %0d: still pending, want idle", cyc);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            n_cmp++;
            if (obs_req[32] !== 1'b0) begin
                n_fail++; $display("FAIL reset_req cyc %0d: got %b want 0", cyc, obs_req[32]);
            end
        end
        n_cmp++;
        if (obs_out !== 98'h0) begin
            n_fail++; $display("FAIL reset_outputs cyc %0d: got %h want 0", cyc, obs_out);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] addrs [4];
        addrs[0] = c_RV; addrs[1] = 32'h0; addrs[2] = 32'h4; addrs[3] = 32'h8;
        lat_lo = 0; lat_hi = 0; mem_lat = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            n_cmp++;
            if (obs_req !== exp_req) begin
                n_fail++; $display("FAIL zero_wait_req cyc %0d: got %h want %h", cyc, obs_req, exp_req);
            end
            n_cmp++;
            if (obs_out !== exp_out) begin
                n_fail++; $display("FAIL zero_wait_out cyc %0d: got %h want %h", cyc, obs_out, exp_out);
            end
            if (i < 4) begin
                n_cmp++;
                if (obs_req !== {1'b1, addrs[i]} || pcF_o !== addrs[i] ||
                    pc_plus4F_o !== addrs[i] + 32'd4 || validF_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL zero_wait_seq cyc %0d: got req %h pc %h pc4 %h v %b want addr %h",
                             cyc, obs_req, pcF_o, pc_plus4F_o, validF_o, addrs[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] held_pc;
        logic [31:0] held_rd;
        held_pc = m_pcF; held_rd = m_rd;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, (i < 4), 1'b0, 32'h0);
            n_cmp++;
            if (obs_out !== exp_out) begin
                n_fail++; $display("FAIL stall_out cyc %0d: got %h want %h", cyc, obs_out, exp_out);
            end
            n_cmp++;
            if (i < 4 && (obs_req[32] !== 1'b0 || pcF_o !== held_pc || rd_o !== held_rd)) begin
                n_fail++; $display("FAIL stall_freeze cyc %0d: got req %b pc %h want req 0 pc %h",
                                   cyc, obs_req[32], pcF_o, held_pc);
            end else if (i == 4 && obs_req[32] !== 1'b1) begin
                n_fail++; $display("FAIL stall_release_req cyc %0d: got %b want 1", cyc, obs_req[32]);
            end
        end
    endtask

    task automatic test_latency();
        int busy_cnt, valid_cnt;
        drain();
        lat_lo = 2; lat_hi = 2; mem_lat = 2;
        busy_cnt = 0; valid_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            n_cmp++;
            if (obs_req !== exp_req) begin
                n_fail++; $display("FAIL latency_req cyc %0d: got %h want %h", cyc, obs_req, exp_req);
            end
            n_cmp++;
            if (obs_out !== exp_out) begin
                n_fail++; $display("FAIL latency_out cyc %0d: got %h want %h", cyc, obs_out, exp_out);
            end
            busy_cnt  += int'(busyF_o === 1'b1);
            valid_cnt += int'(validF_o === 1'b1);
        end
        n_cmp++;
        if (busy_cnt != 6 || valid_cnt != 3) begin
            n_fail++; $display("FAIL latency_counts: got busy %0d valid %0d want busy 6 valid 3",
                               busy_cnt, valid_cnt);
        end
    endtask

    task automatic test_redirect_drop();
        logic [31:0] a_addr;
        drain();
        lat_lo = 3; lat_hi = 3; mem_lat = 3;
        a_addr = m_pc;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, (i == 1), 32'h100);
            n_cmp++;
            if (obs_out !== exp_out) begin
                n_fail++; $display("FAIL drop_out cyc %0d: got %h want %h", cyc, obs_out, exp_out);
            end
            n_cmp++;
            if (i == 1 && (validF_o !== 1'b0 || busyF_o !== 1'b1)) begin
                n_fail++; $display("FAIL drop_enter cyc %0d: got v %b busy %b want v 0 busy 1",
                                   cyc, validF_o, busyF_o);
            end else if (i == 3 && (validF_o !== 1'b0 || busyF_o !== 1'b0 || rd_o === mem_f(a_addr))) begin
                n_fail++; $display("FAIL drop_discard cyc %0d: got v %b busy %b rd %h want v 0 busy 0",
                                   cyc, validF_o, busyF_o, rd_o);
            end else if (i == 4 && obs_req !== {1'b1, 32'h100}) begin
                n_fail++; $display("FAIL drop_target cyc %0d: got %h want %h", cyc, obs_req, {1'b1, 32'h100});
            end
        end
    endtask

    task automatic test_redirect_ack();
        drain();
        lat_lo = 1; lat_hi = 1; mem_lat = 1;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin lat_lo = 0; lat_hi = 0; end
            step(1'b0, (i == 3), (i == 1 || i == 3), (i == 1) ? 32'h200 : 32'h300);
            n_cmp++;
            if (obs_out !== exp_out) begin
                n_fail++; $display("FAIL redir_out cyc %0d: got %h want %h", cyc, obs_out, exp_out);
            end
            n_cmp++;
            if ((i == 1 || i == 3) && validF_o !== 1'b0) begin
                n_fail++; $display("FAIL redir_flush cyc %0d: got %b want 0", cyc, validF_o);
            end else if (i == 2 && (obs_req !== {1'b1, 32'h200} || pcF_o !== 32'h200)) begin
                n_fail++; $display("FAIL redir_ack_target cyc %0d: got %h pc %h want 200", cyc, obs_req, pcF_o);
            end else if (i == 4 && (obs_req !== {1'b1, 32'h300} || pcF_o !== 32'h300 || validF_o !== 1'b1)) begin
                n_fail++; $display("FAIL redir_stall_target cyc %0d: got %h pc %h want 300", cyc, obs_req, pcF_o);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        drain();
        lat_lo = 0; lat_hi = 3;
        for (int i = 0; i < 400; i++) begin
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
            step(1'b0, ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0), tgt);
            n_cmp++;
            if (obs_req !== exp_req) begin
                n_fail++; $display("FAIL random_req cyc %0d: got %h want %h", cyc, obs_req, exp_req);
            end
            n_cmp++;
            if (obs_out !== exp_out) begin
                n_fail++; $display("FAIL random_out cyc %0d: got %h want %h", cyc, obs_out, exp_out);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        drain();
        lat_lo = 5; lat_hi = 5; mem_lat = 5;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (busyF_o !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_busy cyc %0d: got %b want 1", cyc, busyF_o);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (obs_req[32] !== 1'b0 || obs_out !== 98'h0) begin
            n_fail++; $display("FAIL rst_mid_state cyc %0d: got req %b out %h want 0", cyc, obs_req[32], obs_out);
        end
        lat_lo = 0; lat_hi = 0; mem_lat = 0;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        n_cmp++;
        if (obs_req !== {1'b1, c_RV} || pcF_o !== c_RV || pc_plus4F_o !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_restart cyc %0d: got %h pc %h pc4 %h want %h",
                               cyc, obs_req, pcF_o, pc_plus4F_o, c_RV);
        end
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    // Scenario sequence.
    initial begin
        @(negedge clk_i);
        test_reset();
        test_zero_wait();
        test_stall();
        test_latency();
        test_redirect_drop();
        test_redirect_ack();
        test_random();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
